// File: rtl/mbus_master_req_gen.sv
// mbus_master_req_gen
// Master-side request generator for one ISC bus master port. CPU-side
// requests are queued in a small FIFO and issued one at a time. Each command
// is held on the bus until it is acknowledged. After the ack the bus returns
// to NOP for a one-cycle bubble before the next pop.

module mbus_master_req_gen #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,

  // CPU-side request interface
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [2:0]                    req_cmd_i,
  input  logic [ADDR_W-1:0]             req_addr_i,

  // ISC master-side bus interface
  output logic [2:0]                    mbus_cmd_o,
  output logic [ADDR_W-1:0]             mbus_addr_o,
  input  logic                          mbus_ack_i,

  // Status
  output logic                          done_o,
  output logic                          illegal_o,
  output logic                          timeout_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  // Pointer and occupancy widths. The occupancy needs one extra bit so that
  // a full queue can be told apart from an empty one.
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // The timeout counter only needs to reach TIMEOUT_CYCLES. A zero setting
  // turns the check off, but a one-bit counter is still kept so the
  // declarations stay legal.
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  // Bus command encodings
  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_RD_BROAD = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  // Queue storage. The data itself needs no reset because the pointers and
  // the occupancy decide what is valid.
  entry_t fifo_mem [FIFO_DEPTH];

  // Registered state and outputs
  state_t             state_q,   state_d;
  logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic               ready_q,   ready_d;
  logic [2:0]         cmd_q,     cmd_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic               done_q,    done_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               busy_q,    busy_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  // Handshake decode
  logic   cmd_legal;
  logic   accept;
  logic   push;
  logic   pop;
  entry_t head;

  // Decide what happens to the queue this cycle. Illegal commands still
  // complete the handshake but are never written. A pop happens only from
  // IDLE, so the pop and the bus load always occur on the same edge.
  always_comb begin
    cmd_legal = (req_cmd_i != CMD_NOP) && (req_cmd_i <= CMD_RD_BROAD);
    accept    = req_valid_i && ready_q;
    push      = accept && cmd_legal;
    pop       = (state_q == ST_IDLE) && (count_q != CNT_ZERO);
    head      = fifo_mem[rd_ptr_q];
  end

  // Next pointers and occupancy. The pointers wrap naturally because the
  // depth is a power of two. Ready is registered from the next occupancy.
  // Ready was already low when a pop frees a slot from a full queue, so it
  // only rises on the following cycle.
  always_comb begin
    wr_ptr_d  = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d  = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    ready_d   = (count_d != FULL_COUNT);
    illegal_d = accept && !cmd_legal;
  end

  // Issue sequencing: load from the queue head in IDLE, then hold the
  // command until the ack. After the ack, drop to NOP with a single GAP
  // bubble. The address is left as it was after the ack. The timeout
  // counter restarts on every ISSUE entry, saturates at its limit, and
  // sets the sticky flag.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    tmo_cnt_d = tmo_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          cmd_d     = head.cmd;
          addr_d    = head.addr;
          tmo_cnt_d = '0;
          state_d   = ST_ISSUE;
        end else begin
          cmd_d = CMD_NOP;
        end
      end

      ST_ISSUE: begin
        if (mbus_ack_i) begin
          cmd_d   = CMD_NOP;
          done_d  = 1'b1;
          state_d = ST_GAP;
        end else if (TMO_EN) begin
          if (tmo_cnt_q != TMO_LIMIT) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
          if (tmo_cnt_d == TMO_LIMIT) begin
            timeout_d = 1'b1;
          end
        end
      end

      ST_GAP: begin
        cmd_d   = CMD_NOP;
        state_d = ST_IDLE;
      end

      default: begin
        cmd_d   = CMD_NOP;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || (count_d != CNT_ZERO);
  end

  // Queue storage write on an accepted legal request
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{cmd: req_cmd_i, addr: req_addr_i};
    end
  end

  // State and output registers with synchronous reset. A reset during ISSUE
  // drops the in-flight command silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign mbus_cmd_o   = cmd_q;
  assign mbus_addr_o  = addr_q;
  assign done_o       = done_q;
  assign illegal_o    = illegal_q;
  assign timeout_o    = timeout_q;
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_mbus_master_req_gen.sv
// Testbench for mbus_master_req_gen. A queue-based reference model tracks
// the request stream and the expected bus view every cycle. Directed tables
// and sequences cover the latency, ordering, illegal, timeout, reset and
// wrap corners, and a randomized phase follows.

module tb_mbus_master_req_gen;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [2:0]    req_cmd_i;
  logic [AW-1:0] req_addr_i;
  logic [2:0]    mbus_cmd_o;
  logic [AW-1:0] mbus_addr_o;
  logic          mbus_ack_i;
  logic          done_o;
  logic          illegal_o;
  logic          timeout_o;
  logic          busy_o;
  logic [2:0]    fifo_count_o;

  int checks = 0;
  int fails  = 0;

  mbus_master_req_gen #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_cmd_i(req_cmd_i),
    .req_addr_i(req_addr_i),
    .mbus_cmd_o(mbus_cmd_o),
    .mbus_addr_o(mbus_addr_o),
    .mbus_ack_i(mbus_ack_i),
    .done_o(done_o),
    .illegal_o(illegal_o),
    .timeout_o(timeout_o),
    .busy_o(busy_o),
    .fifo_count_o(fifo_count_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model: a queue of stored requests plus a description of what
  // the bus is doing (holding a request, or waiting out NOP bubbles).
  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
  } req_t;

  req_t          mQ[$];
  bit            mHolding;
  int            mBubble;
  int            mWaited;
  logic [2:0]    mCmd;
  logic [AW-1:0] mAddr;
  logic          mDone;
  logic          mIll;
  logic          mTmo;

  // Advance the model by one rising edge, using the inputs sampled at it
  function automatic void modelStep();
    bit   roomBefore;
    req_t r;
    if (rst) begin
      mQ.delete();
      mHolding = 0;
      mBubble  = 0;
      mWaited  = 0;
      mCmd     = 3'd0;
      mAddr    = '0;
      mDone    = 1'b0;
      mIll     = 1'b0;
      mTmo     = 1'b0;
      return;
    end
    roomBefore = (mQ.size() < DEPTH);
    mDone = 1'b0;
    mIll  = 1'b0;
    if (mHolding) begin
      if (mbus_ack_i) begin
        mHolding = 0;
        mDone    = 1'b1;
        mBubble  = 1;
        mCmd     = 3'd0;
      end else begin
        if (mWaited < TMO) mWaited++;
        if (mWaited >= TMO) mTmo = 1'b1;
      end
    end else if (mBubble > 0) begin
      mBubble--;
    end else if (mQ.size() > 0) begin
      r        = mQ.pop_front();
      mHolding = 1;
      mWaited  = 0;
      mCmd     = r.cmd;
      mAddr    = r.addr;
    end
    if (req_valid_i && roomBefore) begin
      if (req_cmd_i >= 3'd1 && req_cmd_i <= 3'd4) begin
        r.cmd  = req_cmd_i;
        r.addr = req_addr_i;
        mQ.push_back(r);
      end else begin
        mIll = 1'b1;
      end
    end
  endfunction

  // Single comparison with failure reporting
  function automatic void checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endfunction

  // Compare every DUT output against the reference model
  task automatic checkOutput();
    checkVal("model_cmd",     32'(mbus_cmd_o),   32'(mCmd));
    checkVal("model_addr",    mbus_addr_o,       mAddr);
    checkVal("model_done",    32'(done_o),       32'(mDone));
    checkVal("model_illegal", 32'(illegal_o),    32'(mIll));
    checkVal("model_timeout", 32'(timeout_o),    32'(mTmo));
    checkVal("model_busy",    32'(busy_o),
             32'(mHolding || mBubble > 0 || mQ.size() > 0));
    checkVal("model_count",   32'(fifo_count_o), 32'(mQ.size()));
    checkVal("model_ready",   32'(req_ready_o),  32'(mQ.size() < DEPTH));
  endtask

  // Drive one cycle of inputs, step the model at the edge, check at negedge
  task automatic applyStimulus(input logic v, input logic [2:0] c,
                               input logic [AW-1:0] a, input logic k,
                               input logic r);
    req_valid_i = v;
    req_cmd_i   = c;
    req_addr_i  = a;
    mbus_ack_i  = k;
    rst         = r;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  // Directed vector table: single RD latency, ack ignored outside ISSUE,
  // illegal command drops
  typedef struct {
    logic          v;
    logic [2:0]    c;
    logic [AW-1:0] a;
    logic          k;
    logic [2:0]    eCmd;
    logic [AW-1:0] eAddr;
    logic          eDone;
    logic          eIll;
    logic [2:0]    eCnt;
    logic          eBusy;
    logic          eReady;
  } vec_t;

  vec_t tbl[12];

  // Hard stop in case anything stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]    expCmds[5];
    logic [AW-1:0] expAddrs[5];
    logic [AW-1:0] pushOrder[$];
    logic [AW-1:0] issued[$];
    logic [AW-1:0] ra;
    int            n;
    int            totalDones;
    logic          ackNow;

    //                v  c     a             k  eCmd  eAddr         D  I  Cnt   B  R
    tbl[0]  = '{1'b1, 3'd2, 32'h0000_1000, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 3'd0, 32'h0000_0000, 1'b0, 3'd2, 32'h0000_1000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 3'd0, 32'h0000_0000, 1'b0, 3'd2, 32'h0000_1000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 3'd0, 32'h0000_0000, 1'b0, 3'd2, 32'h0000_1000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 3'd0, 32'h0000_0000, 1'b1, 3'd0, 32'h0000_1000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 3'd0, 32'h0000_0000, 1'b1, 3'd0, 32'h0000_1000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 3'd0, 32'h0000_0000, 1'b1, 3'd0, 32'h0000_1000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 3'd0, 32'h0000_0055, 1'b0, 3'd0, 32'h0000_1000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 3'd7, 32'h0000_0066, 1'b0, 3'd0, 32'h0000_1000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 3'd0, 32'h0000_0000, 1'b0, 3'd0, 32'h0000_1000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 3'd5, 32'h0000_0077, 1'b0, 3'd0, 32'h0000_1000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 3'd6, 32'h0000_0088, 1'b0, 3'd0, 32'h0000_1000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};

    expCmds  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    expAddrs = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};

    req_valid_i = 1'b0;
    req_cmd_i   = 3'd0;
    req_addr_i  = '0;
    mbus_ack_i  = 1'b0;
    rst         = 1'b1;

    // Reset state
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b1);
    checkVal("reset_cmd",     32'(mbus_cmd_o),   32'd0);
    checkVal("reset_count",   32'(fifo_count_o), 32'd0);
    checkVal("reset_ready",   32'(req_ready_o),  32'd1);
    checkVal("reset_busy",    32'(busy_o),       32'd0);
    checkVal("reset_timeout", 32'(timeout_o),    32'd0);

    // Table-driven directed vectors
    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].k, 1'b0);
      checkVal($sformatf("tbl%0d_cmd", i),   32'(mbus_cmd_o),   32'(tbl[i].eCmd));
      checkVal($sformatf("tbl%0d_addr", i),  mbus_addr_o,       tbl[i].eAddr);
      checkVal($sformatf("tbl%0d_done", i),  32'(done_o),       32'(tbl[i].eDone));
      checkVal($sformatf("tbl%0d_ill", i),   32'(illegal_o),    32'(tbl[i].eIll));
      checkVal($sformatf("tbl%0d_cnt", i),   32'(fifo_count_o), 32'(tbl[i].eCnt));
      checkVal($sformatf("tbl%0d_busy", i),  32'(busy_o),       32'(tbl[i].eBusy));
      checkVal($sformatf("tbl%0d_ready", i), 32'(req_ready_o),  32'(tbl[i].eReady));
    end

    // Five back-to-back pushes with ack withheld, then ordered drain
    $display("[TB] ordering and full queue");
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, expCmds[i], expAddrs[i], 1'b0, 1'b0);
    end
    checkVal("full_ready", 32'(req_ready_o),  32'd0);
    checkVal("full_count", 32'(fifo_count_o), 32'd4);
    applyStimulus(1'b1, 3'd2, 32'h60, 1'b0, 1'b0);
    checkVal("full_drop_count", 32'(fifo_count_o), 32'd4);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        n = 0;
        while (mbus_cmd_o == 3'd0 && n < 10) begin
          n++;
          applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b0);
        end
        checkVal($sformatf("gap_nops%0d", i), 32'(n), 32'd2);
      end
      if (i == 1) checkVal("ready_reopen", 32'(req_ready_o), 32'd1);
      checkVal($sformatf("order_cmd%0d", i),  32'(mbus_cmd_o), 32'(expCmds[i]));
      checkVal($sformatf("order_addr%0d", i), mbus_addr_o,     expAddrs[i]);
      applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd0, '0, 1'b1, 1'b0);
      checkVal($sformatf("order_done%0d", i), 32'(done_o), 32'd1);
    end

    // Ack timeout: sticky flag after the 8th ISSUE cycle, command held
    $display("[TB] timeout");
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd1, 32'hAA, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b0);
      checkVal($sformatf("tmo_flag%0d", i), 32'(timeout_o),  32'(i >= 8));
      checkVal($sformatf("tmo_hold%0d", i), 32'(mbus_cmd_o), 32'd1);
    end
    applyStimulus(1'b0, 3'd0, '0, 1'b1, 1'b0);
    checkVal("tmo_late_done",   32'(done_o),    32'd1);
    checkVal("tmo_still_set",   32'(timeout_o), 32'd1);

    // Reset during ISSUE with three entries queued
    $display("[TB] reset mid-issue");
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'd2, 32'h100 + 32'(i), 1'b0, 1'b0);
    end
    checkVal("pre_rst_count", 32'(fifo_count_o), 32'd3);
    checkVal("pre_rst_cmd",   32'(mbus_cmd_o),   32'd2);
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b1);
    checkVal("rst_cmd",   32'(mbus_cmd_o),   32'd0);
    checkVal("rst_count", 32'(fifo_count_o), 32'd0);
    checkVal("rst_busy",  32'(busy_o),       32'd0);
    checkVal("rst_done",  32'(done_o),       32'd0);
    applyStimulus(1'b0, 3'd0, '0, 1'b1, 1'b0);
    checkVal("rst_late_ack_done", 32'(done_o),     32'd0);
    checkVal("rst_late_ack_cmd",  32'(mbus_cmd_o), 32'd0);

    // Fill and drain three times to exercise pointer wrap
    $display("[TB] fill and drain");
    totalDones = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        ra = $urandom;
        pushOrder.push_back(ra);
        applyStimulus(1'b1, 3'(1 + (i % 4)), ra, 1'b0, 1'b0);
      end
      n = 0;
      while (n < 60 && pushOrder.size() > issued.size()) begin
        ackNow = (mbus_cmd_o != 3'd0);
        if (ackNow) issued.push_back(mbus_addr_o);
        applyStimulus(1'b0, 3'd0, '0, ackNow, 1'b0);
        if (done_o) totalDones++;
        n++;
      end
    end
    checkVal("wrap_dones",  32'(totalDones),   32'd12);
    checkVal("wrap_issued", 32'(issued.size()), 32'd12);
    for (int i = 0; i < 12 && i < issued.size(); i++) begin
      checkVal($sformatf("wrap_addr%0d", i), issued[i], pushOrder[i]);
    end

    // Randomized phase against the model
    $display("[TB] random phase");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(99) < 55), 3'($urandom_range(7)),
                    $urandom, 1'($urandom_range(99) < 30),
                    1'($urandom_range(99) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mbus_master_req_gen.md
Name: mbus_master_req_gen

Overview:
- Per-master request generator driving one master port (mbus_cmdN_i / mbus_addrN_i / mbus_ackN_o) of the MESI ISC bus from the master side.
- Buffers CPU-side requests in a small FIFO and issues them one at a time.
- Holds each command on the bus until acknowledged, then returns the bus to NOP.
- Used in the environment and RTL wrapper as the stimulus/issue stage upstream of the ISC master inputs.

Parameters:
- FIFO_DEPTH, 4, request queue entries (power of 2, >=2)
- ADDR_W, 32, address width
- TIMEOUT_CYCLES, 255, ISSUE cycles without ack before timeout_o sets; 0 disables the check

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid_i  input  1  request offered
- req_ready_o  output  1  queue can accept (= !full)
- req_cmd_i  input  3  command: NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4
- req_addr_i  input  ADDR_W  request address
- mbus_cmd_o  output  3  command to ISC master input
- mbus_addr_o  output  ADDR_W  address to ISC master input
- mbus_ack_i  input  1  ISC ack for this master
- done_o  output  1  one-cycle pulse per acknowledged command
- illegal_o  output  1  one-cycle pulse when an illegal command is dropped
- timeout_o  output  1  sticky ack-timeout flag
- busy_o  output  1  high when FSM not IDLE or queue non-empty
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  queue occupancy

Behaviour:
- Reset, sampled on clk:
  - Flush the FIFO.
  - FSM goes to IDLE; mbus_cmd_o=0, mbus_addr_o=0.
  - done_o, illegal_o, timeout_o, busy_o = 0; fifo_count_o = 0; req_ready_o = 1 in the following cycle.
  - Reset mid-ISSUE drops the in-flight command; no done_o pulse.
- Enqueue:
  - Push on the edge where req_valid_i && req_ready_o.
  - Commands 1..4 are stored.
  - Commands 0, 5, 6, 7 are accepted but not stored; illegal_o pulses in the next cycle.
  - When full, req_ready_o=0. A pop in the same cycle does not reopen ready; ready rises the cycle after the pop.
- FSM states: IDLE, ISSUE, GAP. All bus outputs are registered.
  - IDLE, FIFO non-empty:
    - Pop the head; load mbus_cmd_o/mbus_addr_o; go to ISSUE.
    - Accept at edge T means the command is visible after edge T+1 (2-cycle latency from an empty queue).
  - IDLE, FIFO empty: stay; mbus_cmd_o=0.
  - ISSUE:
    - Hold mbus_cmd_o/mbus_addr_o stable every cycle.
    - On the edge where mbus_ack_i=1: mbus_cmd_o <= 0, mbus_addr_o holds its value, done_o pulses for one cycle, go to GAP.
  - GAP: one-cycle NOP bubble, then IDLE. Back-to-back commands are therefore separated by exactly 2 NOP cycles (GAP + IDLE pop).
  - mbus_ack_i in IDLE or GAP is ignored; no state change and no done_o.
- Timeout:
  - A counter clears on ISSUE entry and increments each ISSUE cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, timeout_o sets and stays set until rst.
  - The command keeps being held (protocol forbids withdrawal). Counter saturates.
- fifo_count_o:
  - Updated on the same edge as push/pop; simultaneous push and pop leaves it unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Order: strict FIFO; no reordering or merging of same-address requests.

Test Plan:
- Reset then single RD addr 0x0000_1000 accepted at edge T, ack at edge T+4 -> mbus_cmd_o=2 after T+1 through T+4; NOP after T+4; done_o high exactly one cycle after T+4.
- Push 5 requests back-to-back with FIFO_DEPTH=4 while ack is withheld:
  - req_ready_o drops once the queue is full.
  - The bus issues in push order WR 0x10, RD 0x20, WR_BROAD 0x30, RD_BROAD 0x40, WR 0x50.
  - Each command is separated by 2 NOP cycles after its ack.
- req_cmd_i=0 and 7 pushed -> illegal_o pulses twice, fifo_count_o stays 0, bus stays NOP.
- TIMEOUT_CYCLES=8, ack withheld 20 cycles -> timeout_o rises after the 8th ISSUE cycle and stays 1; mbus_cmd_o is held throughout. A later ack still produces done_o.
- rst asserted during ISSUE with 3 queued -> the cycle after reset: mbus_cmd_o=0, fifo_count_o=0, busy_o=0, no done_o. An ack arriving afterwards is ignored.
- Fill and drain the FIFO 3 times (12 requests) with ack 1 cycle after issue -> pointer wrap is correct, all 12 done_o pulses occur, and addresses match push order.
